// File: rtl/apb_accel_pkg.sv
// rtl/apb_accel_pkg.sv - register map, STATUS bit indices and FSM state type for apb_accel_slave
package apb_accel_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h40;
    localparam logic [7:0] OFF_STATUS = 8'h44;
    localparam logic [7:0] OFF_RESULT = 8'h48;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_FLAGS_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/apb_accel_ctrl_fsm.sv
// rtl/apb_accel_ctrl_fsm.sv - launch/busy/done sequencer, acc_start pulse, result/flag capture, optional timeout
//
// Optional timeout counter: ACC_TIMEOUT_EN.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   launch, op_in   accepted CTRL write and its op field
//   result_read     a RESULT read completes this cycle (ends DONE)
//   acc_*           accelerator handshake (start/op out, result/flags/valid in)
//   busy, done      current state decode
//   done_entry      BUSY -> DONE transition happens at the coming edge
//   err, result_q, flags_q  captured completion status
module apb_accel_ctrl_fsm
    import apb_accel_pkg::*;
#(
    parameter int OP_W           = 4,
    parameter int FLAG_W         = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  logic [OP_W-1:0]   op_in,
    input  logic              result_read,
    input  logic [31:0]       acc_result,
    input  logic [FLAG_W-1:0] acc_flags,
    input  logic              acc_valid,
    output logic              acc_start,
    output logic [OP_W-1:0]   acc_op,
    output logic              busy,
    output logic              done,
    output logic              done_entry,
    output logic              err,
    output logic [31:0]       result_q,
    output logic [FLAG_W-1:0] flags_q
);

    state_t state_q, state_d;
    logic   start_d;
    logic   timeout_hit;

`ifdef ACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // acc_valid in the same cycle as the limit wins over the timeout
    assign timeout_hit = (state_q == BUSY) && !acc_valid &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        done_entry = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d = BUSY;
                    start_d = 1'b1;
                end else if (state_q == DONE && result_read) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (acc_valid || timeout_hit) begin
                    state_d    = DONE;
                    done_entry = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_start <= 1'b0;
            acc_op    <= '0;
            err       <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_start <= start_d;
            if (launch && state_q != BUSY) begin
                acc_op <= op_in;
                err    <= 1'b0;
            end
            if (done_entry) begin
                if (acc_valid) begin
                    result_q <= acc_result;
                    flags_q  <= acc_flags;
                end else begin
                    // timeout completion: no result from the accelerator
                    result_q <= '0;
                    flags_q  <= '0;
                    err      <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

endmodule

// File: rtl/apb_accel_slave.sv
// rtl/apb_accel_slave.sv - APB3 slave front-end with operand/CTRL/STATUS/RESULT registers for an accelerator
//
// Optional busy timeout: ACC_TIMEOUT_EN (implemented in apb_accel_ctrl_fsm).
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE, PRDATA/PREADY/PSLVERR   APB3 slave
//   acc_start, acc_op, acc_operands  command to the accelerator
//   acc_result, acc_flags, acc_valid completion from the accelerator
module apb_accel_slave
    import apb_accel_pkg::*;
#(
    parameter int          APB_ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h1A10_8000,
    parameter int          NUM_OPS        = 2,
    parameter int          OP_W           = 4,
    parameter int          FLAG_W         = 5,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      acc_start,
    output logic [OP_W-1:0]           acc_op,
    output logic [NUM_OPS*32-1:0]     acc_operands,
    input  logic [31:0]               acc_result,
    input  logic [FLAG_W-1:0]         acc_flags,
    input  logic                      acc_valid
);

    logic [7:0]  off;
    logic        base_hit, is_op, is_ctrl, is_status, is_result, addr_err;
    logic        access, rd_result, wait_st, slverr;
    logic        wr_fire, rd_fire, launch, result_read, op_wr;
    logic        busy, done, done_entry, err;
    logic [31:0] result_q;
    logic [FLAG_W-1:0] flags_q;
    logic [31:0] rdata, status_word;
    // shadow holds the latest written operand; acc_operands follows it except while BUSY
    logic [31:0] shadow   [NUM_OPS];
    logic [31:0] shadow_d [NUM_OPS];

    assign off       = PADDR[7:0];
    assign base_hit  = (PADDR[APB_ADDR_WIDTH-1:8] == BASE_ADDR[APB_ADDR_WIDTH-1:8]);
    assign is_op     = (off[7:6] == 2'b00) && ({1'b0, off[5:2]} < 5'(NUM_OPS));
    assign is_ctrl   = (off == OFF_CTRL);
    assign is_status = (off == OFF_STATUS);
    assign is_result = (off == OFF_RESULT);
    assign addr_err  = !base_hit || (off[1:0] != 2'b00) ||
                       !(is_op || is_ctrl || is_status || is_result);

    assign access    = PSEL && PENABLE;
    assign rd_result = access && !PWRITE && !addr_err && is_result;
    assign wait_st   = rd_result && busy;

    always_comb begin
        slverr = 1'b0;
        if (access && !wait_st) begin
            if (addr_err) begin
                slverr = 1'b1;
            end else if (PWRITE) begin
                slverr = is_status || is_result || (is_ctrl && busy);
            end else begin
                slverr = is_result && err;
            end
        end
    end

    assign PREADY      = !wait_st;
    assign PSLVERR     = slverr;
    assign wr_fire     = access && PWRITE && !slverr;
    assign rd_fire     = access && !PWRITE && !wait_st && !slverr;
    assign launch      = wr_fire && is_ctrl;
    assign op_wr       = wr_fire && is_op;
    // an errored RESULT read still counts as having collected the result
    assign result_read = rd_result && !wait_st;

    apb_accel_ctrl_fsm #(
        .OP_W          (OP_W),
        .FLAG_W        (FLAG_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk        (CLK),
        .rst        (RST),
        .launch     (launch),
        .op_in      (PWDATA[OP_W-1:0]),
        .result_read(result_read),
        .acc_result (acc_result),
        .acc_flags  (acc_flags),
        .acc_valid  (acc_valid),
        .acc_start  (acc_start),
        .acc_op     (acc_op),
        .busy       (busy),
        .done       (done),
        .done_entry (done_entry),
        .err        (err),
        .result_q   (result_q),
        .flags_q    (flags_q)
    );

    always_comb begin
        for (int i = 0; i < NUM_OPS; i++) begin
            shadow_d[i] = (op_wr && off[5:2] == 4'(i)) ? PWDATA : shadow[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                shadow[i] <= '0;
            end
            acc_operands <= '0;
        end else begin
            for (int i = 0; i < NUM_OPS; i++) begin
                shadow[i] <= shadow_d[i];
                // shadow_d so an operand write in the completion cycle is not lost
                if (done_entry || !busy) begin
                    acc_operands[32*i +: 32] <= shadow_d[i];
                end
            end
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[ST_BUSY]                 = busy;
        status_word[ST_DONE]                 = done;
        status_word[ST_ERR]                  = err;
        status_word[ST_FLAGS_LSB +: FLAG_W]  = flags_q;
    end

    always_comb begin
        rdata = '0;
        if (is_op) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (off[5:2] == 4'(i)) begin
                    rdata = shadow[i];
                end
            end
        end else if (is_ctrl) begin
            rdata[OP_W-1:0] = acc_op;
        end else if (is_status) begin
            rdata = status_word;
        end else if (is_result) begin
            rdata = result_q;
        end
    end

    assign PRDATA = rd_fire ? rdata : '0;

endmodule
